usi_ctrl_unit: RTL and testbench

Control unit for the USI: sequences one serial frame per start request, using the configuration held in the USI register map (mode_sel, clkdiv, parameters, tx_data). Contains a baud-tick divider and a shift-engine FSM supporting SPI master (full duplex) and UART transmit. Returns received SPI words to the read buffer and raises ctrl_unit_error, which the register map makes sticky in error_reg[8].

---
 rtl/usi_pkg.sv | 27 ++
 rtl/usi_baud_gen.sv | 21 ++
 rtl/usi_ctrl_unit.sv | 158 +++++++++++++++
 tb/tb_usi_ctrl_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usi_pkg.sv
// rtl/usi_pkg.sv - shared types and parameter-field positions for the USI control unit
package usi_pkg;
  localparam int DATA_W        = 32;
  localparam int LEN_LSB       = 0;
  localparam int LEN_MSB       = 5;
  localparam int MSB_FIRST_BIT = 8;
  localparam int CPOL_BIT      = 9;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_SPI  = 2'b01,
    MODE_UART = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LEAD,
    ST_TRAIL,
    ST_HOLD,
    ST_START_BIT,
    ST_DATA,
    ST_STOP,
    ST_DONE
  } state_t;
endpackage

// File: rtl/usi_baud_gen.sv
// rtl/usi_baud_gen.sv - free-running tick divider, period = period_m1 + 1 cycles
module usi_baud_gen #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] period_m1,
  output logic             tick
);
  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == period_m1);

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tick ? '0 : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end
endmodule

// File: rtl/usi_ctrl_unit.sv
// rtl/usi_ctrl_unit.sv - USI frame sequencer: SPI master (full duplex) and UART transmit
module usi_ctrl_unit #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [1:0]        mode_sel,
  input  logic [DATA_W-1:0] clkdiv,
  input  logic [DATA_W-1:0] parameters,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              start,
  input  logic              serial_in,
  output logic              serial_out,
  output logic              sclk,
  output logic              cs_n,
  output logic              busy,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              ctrl_unit_error
);
  import usi_pkg::*;

  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] FULL_W  = (LEN_W+1)'(DATA_W);

  state_t            state, state_d;
  mode_t             mode_q;
  logic [DATA_W-1:0] div_q, tx_sr, rx_sr, rx_data_q, tx_rev;
  logic [LEN_W:0]    nbits_q, nbits_in, bit_cnt;
  logic              msb_q, cpol_q, half_q, err_q;
  logic              tick, accept, cfg_ok;
  logic              unused_cfg;

  assign unused_cfg = &{1'b0, parameters[DATA_W-1:CPOL_BIT+1],
                        parameters[MSB_FIRST_BIT-1:LEN_LSB+LEN_W]};

  assign nbits_in = {1'b0, parameters[LEN_LSB +: LEN_W]} + CNT_ONE;
  assign cfg_ok   = ((mode_sel == MODE_SPI) || (mode_sel == MODE_UART)) && (|clkdiv);
  assign accept   = start && (state == ST_IDLE) && cfg_ok;

  assign busy            = (state != ST_IDLE);
  assign rx_data         = rx_data_q;
  assign ctrl_unit_error = err_q;

  always_comb begin
    tx_rev = '0;
    for (int i = 0; i < DATA_W; i++) tx_rev[i] = tx_data[DATA_W-1-i];
  end

  usi_baud_gen #(.CNT_W(DATA_W)) u_baud (
    .CLK       (CLK),
    .nRST      (nRST),
    .clr       (accept),
    .en        (busy),
    .period_m1 (div_q),
    .tick      (tick)
  );

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) state <= ST_IDLE;
    else       state <= state_d;
  end

  // The shifter always emits tx_sr[0]; MSB-first frames are pre-reversed within nbits.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      mode_q    <= MODE_OFF;
      div_q     <= '0;
      nbits_q   <= '0;
      msb_q     <= 1'b0;
      cpol_q    <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data_q <= '0;
      bit_cnt   <= '0;
      half_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= start && !accept;
      if (accept) begin
        mode_q  <= mode_t'(mode_sel);
        div_q   <= clkdiv;
        nbits_q <= nbits_in;
        msb_q   <= parameters[MSB_FIRST_BIT];
        cpol_q  <= parameters[CPOL_BIT];
        tx_sr   <= parameters[MSB_FIRST_BIT] ? (tx_rev >> (FULL_W - nbits_in)) : tx_data;
        rx_sr   <= '0;
        bit_cnt <= '0;
        half_q  <= 1'b0;
      end else if (tick) begin
        case (state)
          ST_LEAD: begin
            rx_sr   <= msb_q ? {rx_sr[DATA_W-2:0], serial_in} : {serial_in, rx_sr[DATA_W-1:1]};
            tx_sr   <= tx_sr >> 1;
            bit_cnt <= bit_cnt + CNT_ONE;
          end
          ST_HOLD: rx_data_q <= msb_q ? rx_sr : (rx_sr >> (FULL_W - nbits_q));
          ST_START_BIT, ST_STOP: half_q <= ~half_q;
          ST_DATA: begin
            half_q <= ~half_q;
            if (half_q) begin
              tx_sr   <= tx_sr >> 1;
              bit_cnt <= bit_cnt + CNT_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // UART bits span two ticks; half_q marks the second one.
  always_comb begin
    state_d    = state;
    serial_out = 1'b1;
    sclk       = cpol_q;
    cs_n       = 1'b1;
    rx_valid   = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_d = (mode_sel == MODE_SPI) ? ST_SETUP : ST_START_BIT;
      ST_SETUP: begin
        cs_n = 1'b0; serial_out = tx_sr[0];
        if (tick) state_d = ST_LEAD;
      end
      ST_LEAD: begin
        cs_n = 1'b0; sclk = ~cpol_q; serial_out = tx_sr[0];
        if (tick) state_d = ST_TRAIL;
      end
      ST_TRAIL: begin
        cs_n = 1'b0; serial_out = tx_sr[0];
        if (tick) state_d = (bit_cnt == nbits_q) ? ST_HOLD : ST_LEAD;
      end
      ST_HOLD: begin
        cs_n = 1'b0; serial_out = tx_sr[0];
        if (tick) state_d = ST_DONE;
      end
      ST_START_BIT: begin
        sclk = 1'b0; serial_out = 1'b0;
        if (tick && half_q) state_d = ST_DATA;
      end
      ST_DATA: begin
        sclk = 1'b0; serial_out = tx_sr[0];
        if (tick && half_q && (bit_cnt == nbits_q - CNT_ONE)) state_d = ST_STOP;
      end
      ST_STOP: begin
        sclk = 1'b0;
        if (tick && half_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (mode_q == MODE_UART) sclk = 1'b0;
        rx_valid = (mode_q == MODE_SPI);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_usi_ctrl_unit.sv
// tb/tb_usi_ctrl_unit.sv - randomized bench for usi_ctrl_unit with a frame-level reference model
module tb_usi_ctrl_unit;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [1:0]  mode_sel = 2'b00;
  logic [31:0] clkdiv = 32'd1;
  logic [31:0] parameters = 32'd0;
  logic [31:0] tx_data = 32'd0;
  logic        start = 1'b0;
  logic        serial_in;
  logic        serial_out, sclk, cs_n, busy, rx_valid, ctrl_unit_error;
  logic [31:0] rx_data;
  logic [1:0]  si_mode = 2'b00;

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  // 0: loopback, 1: inverted loopback, 2: tied 0, 3: tied 1
  assign serial_in = si_mode[1] ? si_mode[0] : (serial_out ^ si_mode[0]);

  usi_ctrl_unit dut (
    .CLK(CLK), .nRST(nRST), .mode_sel(mode_sel), .clkdiv(clkdiv),
    .parameters(parameters), .tx_data(tx_data), .start(start),
    .serial_in(serial_in), .serial_out(serial_out), .sclk(sclk), .cs_n(cs_n),
    .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid),
    .ctrl_unit_error(ctrl_unit_error)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
  endtask

  // Frame model: cycle index m_t since the accepting edge, frame ends at m_tdone.
  bit          m_act = 0, m_spi = 0, m_msb = 0, m_cpol = 0, m_err = 0, m_acc = 0;
  int          m_t = 0, m_tdone = 0, m_P = 1, m_n = 1;
  logic [31:0] m_tx = 0, m_rx = 0, m_rx_pend = 0, m_mask = 0;

  function automatic bit mbit(input int i);
    return m_msb ? m_tx[m_n-1-i] : m_tx[i];
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_act = 0; m_cpol = 0; m_rx = 0; m_err = 0; m_t = 0;
    end else begin
      m_err = 0; m_acc = 0;
      if (start) begin
        if (m_act || mode_sel == 2'b00 || mode_sel == 2'b11 || clkdiv == 0) m_err = 1;
        else m_acc = 1;
      end
      if (m_act) begin
        m_t++;
        if (m_spi && m_t == m_tdone) m_rx = m_rx_pend;
        if (m_t > m_tdone) m_act = 0;
      end
      if (m_acc) begin
        m_act = 1; m_t = 0;
        m_spi = (mode_sel == 2'b01);
        m_P = int'(clkdiv) + 1;
        m_n = int'(parameters[5:0]) + 1;
        m_msb = parameters[8];
        m_cpol = parameters[9];
        m_tx = tx_data;
        m_tdone = (m_spi ? 2*m_n + 2 : 2*m_n + 4) * m_P;
        m_mask = (m_n == 32) ? 32'hFFFF_FFFF : ((32'd1 << m_n) - 32'd1);
        case (si_mode)
          2'b00: m_rx_pend = m_tx & m_mask;
          2'b01: m_rx_pend = ~m_tx & m_mask;
          2'b10: m_rx_pend = 32'd0;
          default: m_rx_pend = m_mask;
        endcase
      end
    end
  end

  always @(negedge CLK) begin
    bit e_so, e_sclk, e_csn, c_so;
    int ph, slot;
    e_so = 1; e_sclk = m_cpol; e_csn = 1; c_so = 1;
    if (m_act) begin
      ph = m_t / m_P;
      if (m_spi) begin
        if (m_t == m_tdone) c_so = 0;
        else begin
          e_csn = 0;
          if (ph == 2*m_n + 1) c_so = 0;
          else if (ph % 2 == 1) begin e_sclk = !m_cpol; e_so = mbit((ph-1)/2); end
          else if (ph/2 < m_n) e_so = mbit(ph/2);
          else c_so = 0;
        end
      end else begin
        e_sclk = 0;
        slot = ph / 2;
        if (m_t == m_tdone) e_so = 1;
        else if (slot == 0) e_so = 0;
        else if (slot <= m_n) e_so = mbit(slot-1);
        else e_so = 1;
      end
    end
    chk("busy", busy, m_act);
    chk("cs_n", cs_n, e_csn);
    chk("sclk", sclk, e_sclk);
    if (c_so) chk("serial_out", serial_out, e_so);
    chk("rx_valid", rx_valid, m_act && m_spi && m_t == m_tdone);
    chk("rx_data", rx_data, m_rx);
    chk("ctrl_unit_error", ctrl_unit_error, m_err);
  end

  task automatic issue(input logic [1:0] m, input logic [31:0] d, input logic [31:0] p,
                       input logic [31:0] tx, input logic [1:0] si);
    @(posedge CLK); #1;
    mode_sel = m; clkdiv = d; parameters = p; tx_data = tx; si_mode = si; start = 1;
    @(posedge CLK); #1;
    start = 0;
  endtask

  task automatic err_test(input string nm, input logic [1:0] m, input logic [31:0] d);
    issue(m, d, 32'h107, 32'hFF, 2'b00);
    @(negedge CLK);
    chk({nm, "_err"}, ctrl_unit_error, 1'b1);
    chk({nm, "_busy"}, busy, 1'b0);
    @(negedge CLK);
    chk({nm, "_err_clr"}, ctrl_unit_error, 1'b0);
  endtask

  initial begin
    logic [7:0] mosi, fb;
    logic [9:0] uv;
    logic [31:0] rxd;
    int done_t, rxv, bad, nf, r;
    logic prev;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_serial_out", serial_out, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_rx_data", rx_data, 32'd0);
    @(posedge CLK); #1 nRST = 1;

    // SPI 8-bit MSB-first loopback; config rewritten mid-frame
    issue(2'b01, 32'd1, 32'h107, 32'hA5, 2'b00);
    mosi = 0; done_t = -1; rxv = 0; bad = 0; rxd = 0; prev = sclk;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (sclk && !prev) mosi = {mosi[6:0], serial_out};
      prev = sclk;
      if (rx_valid) begin rxv++; if (done_t < 0) begin done_t = c; rxd = rx_data; end end
      if (c < 36 && cs_n) bad++;
      if (c == 10) begin #1; clkdiv = 32'd7; tx_data = 32'd0; end
    end
    chk("a5_done_cycle", done_t, 32'd36);
    chk("a5_rx_data", rxd, 32'hA5);
    chk("a5_mosi", mosi, 8'hA5);
    chk("a5_rx_valid_cnt", rxv, 32'd1);
    chk("a5_cs_n_high", bad, 32'd0);

    // Async reset in the middle of LEAD
    issue(2'b01, 32'd2, 32'h107, 32'h3C, 2'b00);
    repeat (5) @(negedge CLK);
    chk("lead_sclk", sclk, 1'b1);
    #1 nRST = 0;
    #1;
    chk("arst_serial_out", serial_out, 1'b1);
    chk("arst_sclk", sclk, 1'b0);
    chk("arst_cs_n", cs_n, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_rx_data", rx_data, 32'd0);
    @(posedge CLK); #1 nRST = 1;

    // SPI 32-bit, cpol=1, LSB-first, MISO tied high; a busy start mid-frame
    issue(2'b01, 32'd1, 32'h21F, 32'hDEADBEEF, 2'b11);
    fb = 0; nf = 0; done_t = -1; rxd = 0; prev = sclk;
    for (int c = 0; c < 140; c++) begin
      @(negedge CLK);
      if (c == 0) chk("be_setup_sclk", sclk, 1'b1);
      if (!sclk && prev && nf < 8) begin fb = {serial_out, fb[7:1]}; nf++; end
      prev = sclk;
      if (rx_valid && done_t < 0) begin done_t = c; rxd = rx_data; end
      if (c == 21) begin chk("busy_start_err", ctrl_unit_error, 1'b1); #1 start = 0; end
      if (c == 20) begin #1 start = 1; end
    end
    chk("be_first_byte", fb, 8'hEF);
    chk("be_done_cycle", done_t, 32'd132);
    chk("be_rx_data", rxd, 32'hFFFF_FFFF);
    chk("be_idle_sclk", sclk, 1'b1);

    // UART 8-bit LSB-first, 8 cycles per bit
    issue(2'b10, 32'd3, 32'h007, 32'h55, 2'b00);
    uv = 0; rxv = 0; bad = 0;
    for (int c = 0; c < 85; c++) begin
      @(negedge CLK);
      if (c % 8 == 4 && c < 80) uv[c/8] = serial_out;
      if (rx_valid) rxv++;
      if (sclk || !cs_n) bad++;
    end
    chk("uart_bits", uv, 10'h2AA);
    chk("uart_rx_valid", rxv, 32'd0);
    chk("uart_sclk_cs", bad, 32'd0);

    err_test("mode00", 2'b00, 32'd1);
    err_test("mode11", 2'b11, 32'd1);
    err_test("div0", 2'b01, 32'd0);

    // start on the DONE cycle is rejected, one cycle later accepted
    issue(2'b01, 32'd1, 32'h000, 32'h1, 2'b00);
    repeat (8) @(negedge CLK);
    @(posedge CLK); #1 start = 1;
    @(negedge CLK);
    chk("done_rx_valid", rx_valid, 1'b1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("done_start_err", ctrl_unit_error, 1'b1);
    chk("done_busy_low", busy, 1'b0);
    @(posedge CLK); #1 start = 0;
    @(negedge CLK);
    chk("retry_busy", busy, 1'b1);
    repeat (20) @(posedge CLK);

    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(posedge CLK); #1;
      r = $urandom_range(0, 9);
      mode_sel = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
      clkdiv = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 3));
      parameters = $urandom;
      parameters[5] = 1'b0;
      tx_data = $urandom;
      if (!m_act) si_mode = 2'($urandom_range(0, 3));
      start = m_act ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 3) == 0);
    end
    @(posedge CLK); #1 start = 0;
    repeat (400) @(posedge CLK);
    @(negedge CLK);
    chk("final_idle", busy, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
